audio_gate_pattern: RTL and testbench

- Parametrised stereo rhythmic gate for the codec audio path; sits between the sample source and the audio codec output registers.
- Repeats an audible/muted pattern with independent on and off durations in ticks (default tick = 1 ms).
- Supports hard cut, soft (ramped) gating and a one-shot fade-to-mute, with sample-strobe-qualified, registered stereo outputs.

---
 rtl/audio_gate_pattern.sv | 212 +++++++++++++++++++++
 tb/tb_audio_gate_pattern.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_gate_pattern.sv
// audio_gate_pattern
//   Stereo rhythmic gate placed between the sample source and the codec
//   output registers. Repeats an audible/muted pattern whose on and off
//   lengths are given in ticks, with hard-cut, soft-ramped and one-shot
//   fade-to-mute behaviour.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   BYPASS   | mode 00, unity gain, no timing
//   ON       | audible phase, unity gain, counts on_time ticks
//   FADE_OUT | gain steps down by one per sample strobe until it hits 0
//   OFF      | muted phase, zero gain, counts off_time ticks
//   FADE_IN  | gain steps up by one per sample strobe until it hits unity
//   MUTED    | one-shot end state, zero gain until the mode changes
//
// Ports
//   CLOCK_50                 system clock, rising edge
//   reset                    synchronous active-high reset
//   mode                     00 bypass, 01 hard gate, 10 soft gate, 11 one-shot mute
//   on_time / off_time       phase lengths in ticks (0 behaves as 1)
//   sample_en                one-cycle strobe qualifying the input samples
//   left/right_channel_audio_in   signed input samples
//   left/right_channel_audio_out  registered gated samples
//   out_valid                sample_en delayed by one cycle
//   gate_open                high in BYPASS, ON and FADE_IN
module audio_gate_pattern #(
  parameter int DATA_WIDTH    = 32,
  parameter int CLKS_PER_TICK = 50000,
  parameter int TIME_WIDTH    = 12,
  parameter int GAIN_BITS     = 8
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic [1:0]                   mode,
  input  logic [TIME_WIDTH-1:0]        on_time,
  input  logic [TIME_WIDTH-1:0]        off_time,
  input  logic                         sample_en,
  input  logic signed [DATA_WIDTH-1:0] left_channel_audio_in,
  input  logic signed [DATA_WIDTH-1:0] right_channel_audio_in,
  output logic signed [DATA_WIDTH-1:0] left_channel_audio_out,
  output logic signed [DATA_WIDTH-1:0] right_channel_audio_out,
  output logic                         out_valid,
  output logic                         gate_open
);

  localparam int TICK_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_TICK - 1);
  localparam logic [GAIN_BITS:0] GAIN_UNITY = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic [GAIN_BITS:0] GAIN_ONE   = (GAIN_BITS+1)'(1);
  localparam int PROD_W = DATA_WIDTH + GAIN_BITS + 1;

  typedef enum logic [2:0] {
    ST_BYPASS,
    ST_ON,
    ST_FADE_OUT,
    ST_OFF,
    ST_FADE_IN,
    ST_MUTED
  } state_t;

  state_t                state;
  logic [1:0]            mode_q;
  logic [GAIN_BITS:0]    gain;
  logic [TICK_W-1:0]     tick_cnt;
  logic [TIME_WIDTH-1:0] phase_cnt;
  logic [TIME_WIDTH-1:0] phase_len;

  logic                  tick;
  logic                  phase_done;
  logic [TIME_WIDTH-1:0] on_len;
  logic [TIME_WIDTH-1:0] off_len;

  // A zero-length phase would never expire, so it is stretched to one tick.
  assign on_len  = (on_time  == '0) ? TIME_WIDTH'(1) : on_time;
  assign off_len = (off_time == '0) ? TIME_WIDTH'(1) : off_time;

  assign tick       = (tick_cnt == TICK_LAST);
  assign phase_done = tick && (phase_cnt == phase_len - TIME_WIDTH'(1));

  assign gate_open = (state == ST_BYPASS) || (state == ST_ON) || (state == ST_FADE_IN);

  // Gain is at most 2^GAIN_BITS, so the product never needs more than
  // DATA_WIDTH+GAIN_BITS+1 bits; the arithmetic shift floors toward -inf.
  logic signed [PROD_W-1:0]     left_ext, right_ext, gain_ext;
  logic signed [PROD_W-1:0]     left_prod, right_prod;
  logic signed [DATA_WIDTH-1:0] left_gated, right_gated;

  assign left_ext    = PROD_W'(left_channel_audio_in);
  assign right_ext   = PROD_W'(right_channel_audio_in);
  assign gain_ext    = PROD_W'(gain);
  assign left_prod   = left_ext * gain_ext;
  assign right_prod  = right_ext * gain_ext;
  assign left_gated  = DATA_WIDTH'(left_prod >>> GAIN_BITS);
  assign right_gated = DATA_WIDTH'(right_prod >>> GAIN_BITS);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
      out_valid               <= 1'b0;
      state                   <= ST_BYPASS;
      gain                    <= GAIN_UNITY;
      tick_cnt                <= '0;
      phase_cnt               <= '0;
      phase_len               <= '0;
      mode_q                  <= mode;
    end else begin
      out_valid <= sample_en;
      // Scaling uses the gain held before this edge's update.
      if (sample_en) begin
        left_channel_audio_out  <= left_gated;
        right_channel_audio_out <= right_gated;
      end

      if (mode != mode_q) begin
        // A mode change restarts the pattern and aborts any fade in progress.
        mode_q    <= mode;
        gain      <= GAIN_UNITY;
        tick_cnt  <= '0;
        phase_cnt <= '0;
        phase_len <= on_len;
        state     <= (mode == 2'b00) ? ST_BYPASS : ST_ON;
      end else begin
        case (state)
          ST_BYPASS: begin
            gain      <= GAIN_UNITY;
            tick_cnt  <= '0;
            phase_cnt <= '0;
          end

          ST_ON: begin
            gain     <= GAIN_UNITY;
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            if (tick) phase_cnt <= phase_cnt + TIME_WIDTH'(1);
            if (phase_done) begin
              tick_cnt  <= '0;
              phase_cnt <= '0;
              if (mode_q == 2'b01) begin
                state     <= ST_OFF;
                gain      <= '0;
                phase_len <= off_len;
              end else begin
                state <= ST_FADE_OUT;
              end
            end
          end

          ST_FADE_OUT: begin
            tick_cnt  <= '0;
            phase_cnt <= '0;
            if (sample_en) begin
              if (gain <= GAIN_ONE) begin
                gain <= '0;
                if (mode_q == 2'b11) begin
                  state <= ST_MUTED;
                end else begin
                  state     <= ST_OFF;
                  phase_len <= off_len;
                end
              end else begin
                gain <= gain - GAIN_ONE;
              end
            end
          end

          ST_OFF: begin
            gain     <= '0;
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            if (tick) phase_cnt <= phase_cnt + TIME_WIDTH'(1);
            if (phase_done) begin
              tick_cnt  <= '0;
              phase_cnt <= '0;
              if (mode_q == 2'b01) begin
                state     <= ST_ON;
                gain      <= GAIN_UNITY;
                phase_len <= on_len;
              end else begin
                state <= ST_FADE_IN;
              end
            end
          end

          ST_FADE_IN: begin
            tick_cnt  <= '0;
            phase_cnt <= '0;
            if (sample_en) begin
              if (gain >= GAIN_UNITY - GAIN_ONE) begin
                gain      <= GAIN_UNITY;
                state     <= ST_ON;
                phase_len <= on_len;
              end else begin
                gain <= gain + GAIN_ONE;
              end
            end
          end

          ST_MUTED: begin
            gain      <= '0;
            tick_cnt  <= '0;
            phase_cnt <= '0;
          end

          default: begin
            state <= ST_BYPASS;
            gain  <= GAIN_UNITY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_gate_pattern.sv
// Bench for audio_gate_pattern with a short tick (4 clocks) and 2 gain bits.
// A phase-level reference model (remaining clocks per phase, integer gain,
// floor division) runs alongside every cycle; table rows and hand-written
// sequences add fixed expectations for the documented corner cases.
module tb_audio_gate_pattern;
  localparam int DW  = 32;
  localparam int CPT = 4;
  localparam int TW  = 4;
  localparam int GB  = 2;
  localparam int U   = 4;

  localparam int P_BYP = 0, P_ON = 1, P_FO = 2, P_OFF = 3, P_FI = 4, P_MUT = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [TW-1:0] on_t, off_t;
  logic          sen;
  logic [DW-1:0] in_l, in_r;
  logic [DW-1:0] out_l, out_r;
  logic          out_valid, gate_open;

  always #5 clk = ~clk;

  audio_gate_pattern #(
    .DATA_WIDTH(DW), .CLKS_PER_TICK(CPT), .TIME_WIDTH(TW), .GAIN_BITS(GB)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .mode(mode),
    .on_time(on_t),
    .off_time(off_t),
    .sample_en(sen),
    .left_channel_audio_in(in_l),
    .right_channel_audio_in(in_r),
    .left_channel_audio_out(out_l),
    .right_channel_audio_out(out_r),
    .out_valid(out_valid),
    .gate_open(gate_open)
  );

  int errors = 0;
  int checks = 0;

  // reference model
  int            m_ph, m_left, m_gain;
  logic [1:0]    m_prev;
  logic [DW-1:0] e_l, e_r;
  logic          e_v;

  function automatic int dur(logic [TW-1:0] t);
    return ((t == 0) ? 1 : int'(t)) * CPT;
  endfunction

  function automatic logic [DW-1:0] scale(logic [DW-1:0] x, int g);
    longint p, q;
    p = longint'($signed(x)) * g;
    if (p >= 0) q = p / U;
    else        q = -((-p + U - 1) / U);
    return q[DW-1:0];
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      e_l = '0; e_r = '0; e_v = 1'b0;
      m_ph = P_BYP; m_gain = U; m_left = 0; m_prev = mode;
    end else begin
      e_v = sen;
      if (sen) begin
        e_l = scale(in_l, m_gain);
        e_r = scale(in_r, m_gain);
      end
      if (mode != m_prev) begin
        m_prev = mode;
        m_gain = U;
        m_ph   = (mode == 2'b00) ? P_BYP : P_ON;
        m_left = dur(on_t);
      end else begin
        case (m_ph)
          P_ON: begin
            m_left--;
            if (m_left == 0) begin
              if (m_prev == 2'b01) begin m_ph = P_OFF; m_gain = 0; m_left = dur(off_t); end
              else m_ph = P_FO;
            end
          end
          P_OFF: begin
            m_left--;
            if (m_left == 0) begin
              if (m_prev == 2'b01) begin m_ph = P_ON; m_gain = U; m_left = dur(on_t); end
              else m_ph = P_FI;
            end
          end
          P_FO: if (sen) begin
            m_gain--;
            if (m_gain == 0) begin
              if (m_prev == 2'b11) m_ph = P_MUT;
              else begin m_ph = P_OFF; m_left = dur(off_t); end
            end
          end
          P_FI: if (sen) begin
            m_gain++;
            if (m_gain == U) begin m_ph = P_ON; m_left = dur(on_t); end
          end
          default: ;
        endcase
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, compare at the falling edge.
  task automatic step(logic r, logic [1:0] md, logic [TW-1:0] on, logic [TW-1:0] off,
                      logic s, logic [DW-1:0] l, logic [DW-1:0] rr);
    logic g;
    rst = r; mode = md; on_t = on; off_t = off; sen = s; in_l = l; in_r = rr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    g = (m_ph == P_BYP) || (m_ph == P_ON) || (m_ph == P_FI);
    check("model_left",  out_l, e_l);
    check("model_right", out_r, e_r);
    check("model_valid", DW'(out_valid), DW'(e_v));
    check("model_gate",  DW'(gate_open), DW'(g));
  endtask

  typedef struct {
    logic          r;
    logic [1:0]    md;
    logic [TW-1:0] on, off;
    logic          s;
    logic [DW-1:0] l, rr, xl, xr;
    logic          xv, xg;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int soft_exp[18];
    int gap_vals[4];
    logic [1:0] rmd;
    logic [TW-1:0] ron, roff;

    // reset, bypass, then a hard gate with on=0 (one tick) and off=1
    tbl[0]  = '{1'b1, 2'd0, 4'd0, 4'd1, 1'b1, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 2'd0, 4'd0, 4'd1, 1'b1, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 2'd0, 4'd0, 4'd1, 1'b1, 32'h12345678, 32'hFFFF0000, 32'h12345678, 32'hFFFF0000, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 2'd0, 4'd0, 4'd1, 1'b0, 32'd7, 32'd7, 32'h12345678, 32'hFFFF0000, 1'b0, 1'b1};
    for (int i = 4; i < 14; i++)
      tbl[i] = '{1'b0, 2'd1, 4'd0, 4'd1, 1'b1, 32'd100, 32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 1'b1, 1'b1};
    tbl[8].xg = 1'b0;
    for (int i = 9; i < 13; i++) begin
      tbl[i].xl = 32'd0; tbl[i].xr = 32'd0; tbl[i].xg = (i == 12);
    end

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].md, tbl[i].on, tbl[i].off, tbl[i].s, tbl[i].l, tbl[i].rr);
      check($sformatf("tbl%0d_left", i),  out_l, tbl[i].xl);
      check($sformatf("tbl%0d_right", i), out_r, tbl[i].xr);
      check($sformatf("tbl%0d_valid", i), DW'(out_valid), DW'(tbl[i].xv));
      check($sformatf("tbl%0d_gate", i),  DW'(gate_open), DW'(tbl[i].xg));
    end

    // hard gate on=2, off=3: 8 clocks audible, 12 muted
    step(1'b1, 2'd0, 4'd2, 4'd3, 1'b1, 32'd100, 32'd100);
    for (int c = 0; c < 30; c++) begin
      step(1'b0, 2'd1, 4'd2, 4'd3, 1'b1, 32'd100, 32'd100);
      check("hard_out", out_l, (c <= 8 || (c >= 21 && c <= 28)) ? 32'd100 : 32'd0);
    end

    // soft gate on=1, off=1 with a negative sample at gain 1
    soft_exp = '{100, 100, 100, 100, 100, 100, 75, 50, 25, 0, 0, 0, 0, 0, 25, 50, 75, 100};
    step(1'b1, 2'd0, 4'd1, 4'd1, 1'b1, 32'd100, 32'd100);
    for (int c = 0; c < 18; c++) begin
      step(1'b0, 2'd2, 4'd1, 4'd1, 1'b1, (c == 14) ? -32'sd3 : 32'sd100, 32'd100);
      check("soft_left",  out_l, (c == 14) ? 32'hFFFFFFFF : DW'(soft_exp[c]));
      check("soft_right", out_r, DW'(soft_exp[c]));
    end

    // one-shot mute, then back to bypass
    step(1'b1, 2'd0, 4'd1, 4'd1, 1'b1, 32'd100, 32'd100);
    for (int c = 0; c < 21; c++) begin
      step(1'b0, 2'd3, 4'd1, 4'd1, 1'b1, 32'd100, 32'd100);
      check("oneshot_out", out_l, (c <= 5) ? 32'd100 : (c == 6) ? 32'd75 :
                                  (c == 7) ? 32'd50 : (c == 8) ? 32'd25 : 32'd0);
    end
    check("oneshot_gate", DW'(gate_open), 32'd0);
    step(1'b0, 2'd0, 4'd1, 4'd1, 1'b1, 32'd100, 32'd100);
    check("oneshot_switch", out_l, 32'd0);
    step(1'b0, 2'd0, 4'd1, 4'd1, 1'b1, 32'd100, 32'd100);
    check("oneshot_resume", out_l, 32'd100);

    // strobe every 3rd cycle during the fade-out
    gap_vals = '{100, 75, 50, 25};
    step(1'b1, 2'd0, 4'd1, 4'd1, 1'b1, 32'd100, 32'd100);
    for (int c = 0; c < 17; c++) begin
      logic s;
      s = (c < 5) || (((c - 5) % 3) == 0);
      step(1'b0, 2'd2, 4'd1, 4'd1, s, 32'd100, 32'd100);
      if (c >= 5) begin
        check("gap_out",   out_l, DW'(gap_vals[(c - 5) / 3]));
        check("gap_valid", DW'(out_valid), DW'(s));
      end
    end

    // reset in the middle of a fade-out (gain 2)
    step(1'b1, 2'd0, 4'd1, 4'd1, 1'b1, 32'd100, 32'd100);
    for (int c = 0; c < 7; c++) step(1'b0, 2'd2, 4'd1, 4'd1, 1'b1, 32'd100, 32'd100);
    step(1'b1, 2'd2, 4'd1, 4'd1, 1'b1, 32'd100, 32'd100);
    check("rstfade_out",   out_l, 32'd0);
    check("rstfade_valid", DW'(out_valid), 32'd0);
    check("rstfade_gate",  DW'(gate_open), 32'd1);
    step(1'b0, 2'd2, 4'd1, 4'd1, 1'b1, 32'd100, 32'd100);
    check("rstfade_after", out_l, 32'd100);

    // randomized traffic against the model
    rmd = 2'd0; ron = 4'd1; roff = 4'd1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 79) == 0) rmd = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) ron = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) roff = 4'($urandom_range(0, 3));
      step(($urandom_range(0, 299) == 0), rmd, ron, roff,
           ($urandom_range(0, 9) < 7), $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
